warp_line_coalescer: RTL and testbench

- Per-warp memory access coalescer between the execution unit and the L1/memory side.
- Accepts one warp-wide access with per-thread addresses and a thread mask. Groups active threads by cache line and issues one line-wide downstream transaction per unique line.
- Scatters read data back to each thread and returns the completed warp result over a valid/ready handshake.
- Parametrised successor of the fixed 32-thread, 128B, word-only coalescing path. It adds line-granular grouping, byte-strobed line writes, backpressure on every interface, and statistics.

---
 rtl/warp_line_coalescer.sv | 212 +++++++++++++++++++++
 tb/tb_warp_line_coalescer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_line_coalescer.sv
// Per-warp line coalescer: groups active threads by cache line, issues one line
// request per unique line, scatters read data back and returns the warp result.
module warp_line_coalescer #(
   parameter int unsigned THREADS_PER_WARP = 32,
   parameter int unsigned ADDR_W           = 32,
   parameter int unsigned DATA_W           = 32,
   parameter int unsigned LINE_BYTES       = 128,
   parameter int unsigned WARP_ID_W        = 6
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [ADDR_W*THREADS_PER_WARP-1:0]   in_addr,
   input  logic [DATA_W*THREADS_PER_WARP-1:0]   in_wdata,
   input  logic [THREADS_PER_WARP-1:0]          in_mask,
   input  logic                                 in_write,
   input  logic [WARP_ID_W-1:0]                 in_warp_id,
   output logic                                 req_valid,
   input  logic                                 req_ready,
   output logic [ADDR_W-1:0]                    req_addr,
   output logic                                 req_write,
   output logic [LINE_BYTES*8-1:0]              req_wdata,
   output logic [LINE_BYTES-1:0]                req_wstrb,
   input  logic                                 resp_valid,
   output logic                                 resp_ready,
   input  logic [LINE_BYTES*8-1:0]              resp_rdata,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [DATA_W*THREADS_PER_WARP-1:0]   out_rdata,
   output logic [THREADS_PER_WARP-1:0]          out_mask,
   output logic [WARP_ID_W-1:0]                 out_warp_id,
   output logic                                 out_write,
   output logic [31:0]                          stat_warps,
   output logic [31:0]                          stat_lines
);
   localparam int unsigned T      = THREADS_PER_WARP;
   localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
   localparam int unsigned WB     = DATA_W / 8;
   localparam int unsigned WB_LOG = $clog2(WB);
   localparam int unsigned WPL    = LINE_BYTES / WB;
   localparam int unsigned TAG_W  = ADDR_W - OFF_W;
   localparam int unsigned LINE_W = LINE_BYTES * 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e                 state_q, state_d;
   logic                   alive_q;
   logic [ADDR_W*T-1:0]    addr_q, addr_d;
   logic [DATA_W*T-1:0]    wdata_q, wdata_d;
   logic [DATA_W*T-1:0]    out_rdata_q, out_rdata_d;
   logic [T-1:0]           mask_q, mask_d;
   logic [T-1:0]           pending_q, pending_d;
   logic [T-1:0]           group_q, group_d;
   logic                   write_q, write_d;
   logic [WARP_ID_W-1:0]   warp_id_q, warp_id_d;
   logic [31:0]            stat_warps_q, stat_warps_d;
   logic [31:0]            stat_lines_q, stat_lines_d;

   logic                   accept;
   logic [TAG_W-1:0]       line_tag;
   logic [T-1:0]           issue_group;
   logic [LINE_W-1:0]      line_wdata;
   logic [LINE_BYTES-1:0]  line_wstrb;

   function automatic int unsigned word_idx(input logic [OFF_W-1:0] off);
      return 32'(off >> WB_LOG);
   endfunction

   assign accept = in_valid && in_ready;

   // Grouping: the leader is the lowest pending thread; ascending thread order
   // makes the highest-index writer of a word win.
   always_comb begin
      line_tag = '0;
      for (int unsigned i = T; i > 0; i--) begin
         if (pending_q[i-1]) line_tag = addr_q[(i-1)*ADDR_W + OFF_W +: TAG_W];
      end
      issue_group = '0;
      line_wdata  = '0;
      line_wstrb  = '0;
      for (int unsigned t = 0; t < T; t++) begin
         if (pending_q[t] && addr_q[t*ADDR_W + OFF_W +: TAG_W] == line_tag) begin
            issue_group[t] = 1'b1;
            for (int unsigned w = 0; w < WPL; w++) begin
               if (word_idx(addr_q[t*ADDR_W +: OFF_W]) == w) begin
                  line_wdata[w*DATA_W +: DATA_W] = wdata_q[t*DATA_W +: DATA_W];
                  line_wstrb[w*WB +: WB]         = '1;
               end
            end
         end
      end
   end

   always_comb begin
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mask_d       = mask_q;
      write_d      = write_q;
      warp_id_d    = warp_id_q;
      pending_d    = pending_q;
      group_d      = group_q;
      out_rdata_d  = out_rdata_q;
      stat_warps_d = stat_warps_q;
      stat_lines_d = stat_lines_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d       = in_addr;
               wdata_d      = in_wdata;
               mask_d       = in_mask;
               write_d      = in_write;
               warp_id_d    = in_warp_id;
               pending_d    = in_mask;
               out_rdata_d  = '0;
               stat_warps_d = stat_warps_q + 32'd1;
            end
         end
         ISSUE: begin
            if (req_ready) begin
               group_d      = issue_group;
               stat_lines_d = stat_lines_q + 32'd1;
            end
         end
         WAIT: begin
            if (resp_valid) begin
               pending_d = pending_q & ~group_q;
               if (!write_q) begin
                  for (int unsigned t = 0; t < T; t++) begin
                     for (int unsigned w = 0; w < WPL; w++) begin
                        if (group_q[t] && word_idx(addr_q[t*ADDR_W +: OFF_W]) == w)
                           out_rdata_d[t*DATA_W +: DATA_W] = resp_rdata[w*DATA_W +: DATA_W];
                     end
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept) state_d = (in_mask != '0) ? ISSUE : DONE;
         ISSUE: if (req_ready) state_d = WAIT;
         WAIT:  if (resp_valid) state_d = ((pending_q & ~group_q) != '0) ? ISSUE : DONE;
         DONE:  if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // alive_q holds in_ready low until the first edge after reset release.
   always_comb begin
      in_ready    = alive_q && (state_q == IDLE);
      req_valid   = (state_q == ISSUE);
      req_addr    = '0;
      req_write   = 1'b0;
      req_wdata   = '0;
      req_wstrb   = '0;
      if (state_q == ISSUE) begin
         req_addr  = {line_tag, {OFF_W{1'b0}}};
         req_write = write_q;
         if (write_q) begin
            req_wdata = line_wdata;
            req_wstrb = line_wstrb;
         end
      end
      resp_ready  = (state_q == WAIT);
      out_valid   = (state_q == DONE);
      out_rdata   = out_rdata_q;
      out_mask    = mask_q;
      out_warp_id = warp_id_q;
      out_write   = write_q;
      stat_warps  = stat_warps_q;
      stat_lines  = stat_lines_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
         write_q      <= 1'b0;
         warp_id_q    <= '0;
         pending_q    <= '0;
         group_q      <= '0;
         out_rdata_q  <= '0;
         stat_warps_q <= '0;
         stat_lines_q <= '0;
      end else begin
         alive_q      <= 1'b1;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
         write_q      <= write_d;
         warp_id_q    <= warp_id_d;
         pending_q    <= pending_d;
         group_q      <= group_d;
         out_rdata_q  <= out_rdata_d;
         stat_warps_q <= stat_warps_d;
         stat_lines_q <= stat_lines_d;
      end
   end

endmodule

// File: tb/tb_warp_line_coalescer.sv
// Self-checking bench for warp_line_coalescer: directed scenarios plus random
// warps compared against a line-grouping reference model.
module tb_warp_line_coalescer;
   localparam int T = 32, AW = 32, DW = 32, LB = 128, IW = 6, LW = LB * 8;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 0, in_ready, in_write = 0;
   logic [AW*T-1:0] in_addr = '0;
   logic [DW*T-1:0] in_wdata = '0;
   logic [T-1:0] in_mask = '0;
   logic [IW-1:0] in_warp_id = '0;
   logic req_valid, req_ready = 0, req_write;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_wdata;
   logic [LB-1:0] req_wstrb;
   logic resp_valid = 0, resp_ready;
   logic [LW-1:0] resp_rdata = '0;
   logic out_valid, out_ready = 0, out_write;
   logic [DW*T-1:0] out_rdata;
   logic [T-1:0] out_mask;
   logic [IW-1:0] out_warp_id;
   logic [31:0] stat_warps, stat_lines;

   always #5 clk = ~clk;

   warp_line_coalescer #(.THREADS_PER_WARP(T), .ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB), .WARP_ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_mask(in_mask), .in_write(in_write), .in_warp_id(in_warp_id),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_mask(out_mask), .out_warp_id(out_warp_id), .out_write(out_write),
      .stat_warps(stat_warps), .stat_lines(stat_lines));

   int checks = 0, errors = 0;
   int exp_warps = 0, exp_lines = 0;

   // Warp to send
   logic [31:0] w_addr[T];
   logic [31:0] w_wdata[T];
   logic [T-1:0] w_mask;
   logic w_write;
   logic [IW-1:0] w_id;
   logic [31:0] salt;

   // Observed
   logic [AW-1:0] o_addr[$];
   logic o_wr[$];
   logic [LW-1:0] o_wdata[$];
   logic [LB-1:0] o_wstrb[$];
   int o_first_req, o_out_rel, o_unstable, o_proto, o_early_ready;
   logic o_timeout, o_ready_after;
   logic [DW*T-1:0] o_rdata;
   logic [T-1:0] o_mask;
   logic [IW-1:0] o_id;
   logic o_write;

   // Expected
   logic [AW-1:0] e_addr[$];
   logic [LW-1:0] e_wdata[$];
   logic [LB-1:0] e_wstrb[$];
   logic [DW*T-1:0] e_rdata;

   function automatic logic [31:0] resp_word(input logic [31:0] line, input int i);
      return 32'hA000 + 32'(i) + salt * (line >> 7);
   endfunction

   // Reference: one request per distinct line in order of first appearance among
   // active threads; later threads overwrite earlier ones on the same word.
   task automatic build_model();
      logic [31:0] lines[$];
      logic [31:0] ln;
      logic [LW-1:0] d;
      logic [LB-1:0] s;
      bit seen;
      int w;
      e_addr.delete(); e_wdata.delete(); e_wstrb.delete();
      e_rdata = '0;
      for (int t = 0; t < T; t++) begin
         if (w_mask[t]) begin
            ln = w_addr[t] & ~32'(LB - 1);
            seen = 0;
            foreach (lines[k]) if (lines[k] == ln) seen = 1;
            if (!seen) lines.push_back(ln);
            if (!w_write) e_rdata[t*DW +: DW] = resp_word(ln, int'((w_addr[t] % LB) / 4));
         end
      end
      foreach (lines[k]) begin
         d = '0; s = '0;
         for (int t = 0; t < T; t++) begin
            if (w_write && w_mask[t] && (w_addr[t] & ~32'(LB - 1)) == lines[k]) begin
               w = int'((w_addr[t] % LB) / 4);
               d[w*DW +: DW] = w_wdata[t];
               s[w*4 +: 4] = 4'hF;
            end
         end
         e_addr.push_back(lines[k]); e_wdata.push_back(d); e_wstrb.push_back(s);
      end
   endtask

   function automatic int req_diff();
      if (o_addr.size() != e_addr.size()) return 1000;
      foreach (e_addr[k])
         if (o_addr[k] !== e_addr[k] || o_wr[k] !== w_write || o_wdata[k] !== e_wdata[k] || o_wstrb[k] !== e_wstrb[k])
            return k;
      return -1;
   endfunction

   function automatic bit outputs_nonzero();
      return in_ready | req_valid | req_write | resp_ready | out_valid | out_write | (|req_addr) |
             (|req_wdata) | (|req_wstrb) | (|out_rdata) | (|out_mask) | (|out_warp_id) | (|stat_warps) | (|stat_lines);
   endfunction

   // Sends w_* as one warp and plays the downstream memory and the consumer,
   // recording what the DUT does; the calling test judges the record.
   task automatic do_warp(input int req_stall, input int resp_dly, input int out_stall);
      int rel, guard, stall_left, dly;
      bit awaiting, stalled, out_seen, done;
      logic [AW-1:0] p_addr, resp_line;
      logic p_wr;
      logic [LW-1:0] p_wdata;
      logic [LB-1:0] p_wstrb;
      o_addr.delete(); o_wr.delete(); o_wdata.delete(); o_wstrb.delete();
      o_first_req = -1; o_out_rel = -1; o_unstable = 0; o_proto = 0; o_early_ready = 0;
      o_timeout = 0; o_ready_after = 0;
      @(negedge clk);
      for (int t = 0; t < T; t++) begin
         in_addr[t*AW +: AW] = w_addr[t];
         in_wdata[t*DW +: DW] = w_wdata[t];
      end
      in_mask = w_mask; in_write = w_write; in_warp_id = w_id; in_valid = 1;
      guard = 0;
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
      if (!in_ready) begin o_timeout = 1; in_valid = 0; return; end
      @(posedge clk); #1;
      in_valid = 0;
      for (int t = 0; t < T; t++) begin
         in_addr[t*AW +: AW] = $urandom;
         in_wdata[t*DW +: DW] = $urandom;
      end
      in_mask = $urandom; in_write = ~w_write; in_warp_id = ~w_id;
      rel = 0; stall_left = req_stall; stalled = 0; awaiting = 0; done = 0; out_seen = 0; dly = 0;
      p_addr = '0; p_wr = 0; p_wdata = '0; p_wstrb = '0; resp_line = '0;
      while (!done && rel < 3000) begin
         @(negedge clk); rel++;
         req_ready = 0; resp_valid = 0; out_ready = 0;
         for (int i = 0; i < LW / 32; i++) resp_rdata[i*32 +: 32] = $urandom;
         if (in_ready) o_early_ready++;
         if (awaiting) begin
            if (req_valid) o_proto++;
            if (dly > 0) dly--;
            else begin
               if (!resp_ready) o_proto++;
               resp_valid = 1; awaiting = 0;
               for (int i = 0; i < LB / 4; i++) resp_rdata[i*DW +: DW] = resp_word(resp_line, i);
            end
         end else if (req_valid) begin
            if (o_first_req < 0) o_first_req = rel;
            if (stalled && {req_addr, req_write, req_wdata, req_wstrb} !== {p_addr, p_wr, p_wdata, p_wstrb})
               o_unstable++;
            if (stall_left > 0) begin
               stall_left--; stalled = 1;
               p_addr = req_addr; p_wr = req_write; p_wdata = req_wdata; p_wstrb = req_wstrb;
            end else begin
               req_ready = 1; stalled = 0;
               o_addr.push_back(req_addr); o_wr.push_back(req_write);
               o_wdata.push_back(req_wdata); o_wstrb.push_back(req_wstrb);
               resp_line = req_addr; awaiting = 1; dly = resp_dly; stall_left = req_stall;
            end
         end else if (stalled) o_unstable++;
         if (out_valid) begin
            if (!out_seen) o_out_rel = rel;
            else if ({out_rdata, out_mask, out_warp_id, out_write} !== {o_rdata, o_mask, o_id, o_write})
               o_unstable++;
            out_seen = 1;
            o_rdata = out_rdata; o_mask = out_mask; o_id = out_warp_id; o_write = out_write;
            if (out_stall > 0) out_stall--;
            else begin out_ready = 1; done = 1; end
         end
      end
      if (!done) o_timeout = 1;
      @(negedge clk);
      o_ready_after = in_ready;
      out_ready = 0; resp_valid = 0; req_ready = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      checks++; if (outputs_nonzero()) begin errors++; $display("FAIL reset_outputs: some output nonzero, want all 0"); end
      checks++; if (stat_warps !== 0 || stat_lines !== 0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_warps, stat_lines); end
      rst_n = 1; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b want 0", in_ready); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b want 1", in_ready); end
      exp_warps = 0; exp_lines = 0;
   endtask

   task automatic test_full_line_read();
      salt = 0;
      for (int t = 0; t < T; t++) begin w_addr[t] = 32'h1000 + 32'(4 * t); w_wdata[t] = $urandom; end
      w_mask = '1; w_write = 0; w_id = 6'd5;
      build_model(); do_warp(0, 0, 0);
      exp_warps++; exp_lines += e_addr.size();
      checks++; if (o_timeout) begin errors++; $display("FAIL rd32_timeout: got timeout want completion"); end
      checks++; if (o_addr.size() != 1 || o_addr[0] !== 32'h1000) begin errors++; $display("FAIL rd32_req: got %0d reqs first %h want 1 req 00001000", o_addr.size(), o_addr.size() ? o_addr[0] : 'x); end
      checks++; if (req_diff() != -1) begin errors++; $display("FAIL rd32_reqfields: differs at %0d want none", req_diff()); end
      checks++; if (o_rdata[31*DW +: DW] !== 32'hA01F || o_rdata !== e_rdata) begin errors++; $display("FAIL rd32_rdata: got t31=%h want 0000a01f (full vector mismatch=%b)", o_rdata[31*DW +: DW], o_rdata !== e_rdata); end
      checks++; if (o_first_req !== 1 || o_out_rel !== 3) begin errors++; $display("FAIL rd32_latency: got req@%0d out@%0d want 1/3", o_first_req, o_out_rel); end
      checks++; if (stat_lines !== 1 || stat_warps !== 1) begin errors++; $display("FAIL rd32_stats: got %0d/%0d want 1/1", stat_warps, stat_lines); end
      checks++; if (o_id !== 6'd5 || o_mask !== '1 || o_write !== 0) begin errors++; $display("FAIL rd32_meta: got id %0d mask %h wr %b want 5 ffffffff 0", o_id, o_mask, o_write); end
      checks++; if (o_ready_after !== 1) begin errors++; $display("FAIL rd32_throughput: got in_ready %b want 1", o_ready_after); end
   endtask

   task automatic test_strided_read();
      salt = 3;
      for (int t = 0; t < T; t++) begin w_addr[t] = (t < 4) ? 32'h2000 + 32'(128 * t) : $urandom; w_wdata[t] = $urandom; end
      w_mask = 32'hF; w_write = 0; w_id = 6'd9;
      build_model(); do_warp(0, 0, 0);
      exp_warps++; exp_lines += e_addr.size();
      checks++; if (o_addr.size() != 4 || o_addr[0] !== 32'h2000 || o_addr[1] !== 32'h2080 || o_addr[2] !== 32'h2100 || o_addr[3] !== 32'h2180) begin errors++; $display("FAIL stride_order: got %0d reqs want 2000,2080,2100,2180", o_addr.size()); end
      checks++; if (req_diff() != -1) begin errors++; $display("FAIL stride_reqfields: differs at %0d want none", req_diff()); end
      checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL stride_rdata: got t3=%h want %h", o_rdata[3*DW +: DW], e_rdata[3*DW +: DW]); end
      checks++; if (o_out_rel !== 9) begin errors++; $display("FAIL stride_latency: got %0d want 9", o_out_rel); end
      checks++; if (stat_lines !== 32'(exp_lines)) begin errors++; $display("FAIL stride_stat_lines: got %0d want %0d", stat_lines, exp_lines); end
   endtask

   task automatic test_zero_mask();
      for (int t = 0; t < T; t++) begin w_addr[t] = $urandom; w_wdata[t] = $urandom; end
      w_mask = '0; w_write = 0; w_id = 6'd33;
      build_model(); do_warp(0, 0, 0);
      exp_warps++;
      checks++; if (o_addr.size() != 0 || o_first_req != -1) begin errors++; $display("FAIL zero_noreq: got %0d reqs want 0", o_addr.size()); end
      checks++; if (o_out_rel !== 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", o_out_rel); end
      checks++; if (o_rdata !== '0) begin errors++; $display("FAIL zero_rdata: got nonzero want 0"); end
      checks++; if (stat_warps !== 32'(exp_warps) || stat_lines !== 32'(exp_lines)) begin errors++; $display("FAIL zero_stats: got %0d/%0d want %0d/%0d", stat_warps, stat_lines, exp_warps, exp_lines); end
   endtask

   task automatic test_write_merge();
      for (int t = 0; t < T; t++) begin w_addr[t] = $urandom; w_wdata[t] = $urandom; end
      w_addr[0] = 32'h3004; w_wdata[0] = 32'h11;
      w_addr[5] = 32'h3004; w_wdata[5] = 32'h55;
      w_addr[1] = 32'h3010; w_wdata[1] = 32'hDEADBEEF;
      w_mask = 32'h23; w_write = 1; w_id = 6'd17;
      build_model(); do_warp(0, 0, 0);
      exp_warps++; exp_lines += e_addr.size();
      checks++; if (o_addr.size() != 1 || o_addr[0] !== 32'h3000 || o_wr[0] !== 1) begin errors++; $display("FAIL wr_req: got %0d reqs want 1 write at 3000", o_addr.size()); end
      checks++; if (o_wdata[0][63:32] !== 32'h55 || o_wdata[0][159:128] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data: got w1=%h w4=%h want 55 deadbeef", o_wdata[0][63:32], o_wdata[0][159:128]); end
      checks++; if (o_wstrb[0] !== 128'hF00F0) begin errors++; $display("FAIL wr_strb: got %h want f00f0", o_wstrb[0]); end
      checks++; if (req_diff() != -1) begin errors++; $display("FAIL wr_reqfields: differs at %0d want none", req_diff()); end
      checks++; if (o_rdata !== '0 || o_write !== 1 || o_out_rel !== 3) begin errors++; $display("FAIL wr_done: got wr %b out@%0d want 1 out@3 rdata 0", o_write, o_out_rel); end
   endtask

   task automatic test_backpressure();
      salt = 11;
      for (int t = 0; t < T; t++) begin w_addr[t] = 32'h5000 + 32'(128 * (t % 2)) + 32'(4 * t); w_wdata[t] = $urandom; end
      w_mask = '1; w_write = 0; w_id = 6'd42;
      build_model(); do_warp(5, 1, 3);
      exp_warps++; exp_lines += e_addr.size();
      checks++; if (o_unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", o_unstable); end
      checks++; if (o_proto !== 0) begin errors++; $display("FAIL bp_protocol: got %0d violations want 0", o_proto); end
      checks++; if (o_addr.size() != 2 || req_diff() != -1) begin errors++; $display("FAIL bp_reqs: got %0d reqs want 2 matching", o_addr.size()); end
      checks++; if (o_early_ready !== 0 || o_ready_after !== 1) begin errors++; $display("FAIL bp_in_ready: got early %0d after %b want 0/1", o_early_ready, o_ready_after); end
      checks++; if (o_rdata !== e_rdata || o_id !== 6'd42) begin errors++; $display("FAIL bp_result: got t1=%h id %0d want %h 42", o_rdata[DW +: DW], o_id, e_rdata[DW +: DW]); end
   endtask

   task automatic test_random();
      logic [31:0] base;
      bit nodelay;
      for (int n = 0; n < 40; n++) begin
         base = $urandom & 32'hFFFF_F000;
         for (int t = 0; t < T; t++) begin
            w_addr[t] = base + 32'(128 * $urandom_range(0, 5)) + 32'($urandom_range(0, 127));
            w_wdata[t] = $urandom;
         end
         w_mask = (n % 8 == 3) ? '0 : ((n % 4 == 0) ? '1 : $urandom);
         w_write = 1'($urandom_range(0, 1)); w_id = 6'($urandom); salt = $urandom;
         nodelay = (n % 2 == 0);
         build_model();
         if (nodelay) do_warp(0, 0, 0);
         else do_warp($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         exp_warps++; exp_lines += e_addr.size();
         checks++; if (o_timeout || req_diff() != -1) begin errors++; $display("FAIL rand_reqs[%0d]: timeout %b diff@%0d got %0d reqs want %0d", n, o_timeout, req_diff(), o_addr.size(), e_addr.size()); end
         checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got t0=%h want %h", n, o_rdata[DW-1:0], e_rdata[DW-1:0]); end
         checks++; if ({o_mask, o_id, o_write} !== {w_mask, w_id, w_write}) begin errors++; $display("FAIL rand_meta[%0d]: got %h/%0d/%b want %h/%0d/%b", n, o_mask, o_id, o_write, w_mask, w_id, w_write); end
         checks++; if (o_unstable + o_proto + o_early_ready != 0 || o_ready_after !== 1) begin errors++; $display("FAIL rand_protocol[%0d]: got %0d/%0d/%0d want 0/0/0", n, o_unstable, o_proto, o_early_ready); end
         checks++; if (stat_warps !== 32'(exp_warps) || stat_lines !== 32'(exp_lines)) begin errors++; $display("FAIL rand_stats[%0d]: got %0d/%0d want %0d/%0d", n, stat_warps, stat_lines, exp_warps, exp_lines); end
         if (nodelay) begin
            checks++; if (o_out_rel !== 1 + 2 * e_addr.size()) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, o_out_rel, 1 + 2 * e_addr.size()); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard, leak;
      salt = 7;
      for (int t = 0; t < T; t++) begin w_addr[t] = 32'h6000 + 32'(128 * (t % 3)) + 32'(4 * t); w_wdata[t] = $urandom; end
      w_mask = '1; w_write = 0; w_id = 6'd3;
      @(negedge clk);
      for (int t = 0; t < T; t++) in_addr[t*AW +: AW] = w_addr[t];
      in_mask = w_mask; in_write = 0; in_warp_id = w_id; in_valid = 1;
      guard = 0;
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
      @(posedge clk); #1;
      in_valid = 0; req_ready = 1;
      @(negedge clk);
      checks++; if (req_valid !== 1 || req_addr !== 32'h6000) begin errors++; $display("FAIL mid_req: got %b %h want 1 00006000", req_valid, req_addr); end
      @(negedge clk);
      req_ready = 0;
      checks++; if (resp_ready !== 1) begin errors++; $display("FAIL mid_wait: got resp_ready %b want 1", resp_ready); end
      #2 rst_n = 0; #1;
      checks++; if (outputs_nonzero()) begin errors++; $display("FAIL mid_reset_outputs: some output nonzero, want all 0"); end
      resp_valid = 1;
      for (int i = 0; i < LB / 4; i++) resp_rdata[i*DW +: DW] = resp_word(32'h6000, i);
      repeat (2) @(negedge clk);
      rst_n = 1; leak = 0;
      repeat (4) begin @(negedge clk); if (resp_ready | req_valid | out_valid) leak++; end
      resp_valid = 0;
      checks++; if (leak !== 0 || stat_warps !== 0 || stat_lines !== 0) begin errors++; $display("FAIL mid_ignore: got leak %0d stats %0d/%0d want 0 0/0", leak, stat_warps, stat_lines); end
      exp_warps = 0; exp_lines = 0;
      salt = 13;
      for (int t = 0; t < T; t++) begin w_addr[t] = 32'h7000 + 32'(128 * (t % 2)) + 32'($urandom_range(0, 127)); w_wdata[t] = $urandom; end
      w_mask = $urandom; w_write = 0; w_id = 6'd21;
      build_model(); do_warp(0, 0, 0);
      exp_warps++; exp_lines += e_addr.size();
      checks++; if (o_timeout || req_diff() != -1 || o_rdata !== e_rdata) begin errors++; $display("FAIL mid_fresh: got %0d reqs rdata_ok %b want %0d reqs rdata_ok 1", o_addr.size(), o_rdata === e_rdata, e_addr.size()); end
      checks++; if (stat_warps !== 1 || stat_lines !== 32'(exp_lines)) begin errors++; $display("FAIL mid_fresh_stats: got %0d/%0d want 1/%0d", stat_warps, stat_lines, exp_lines); end
   endtask

   initial begin
      test_reset();
      test_full_line_read();
      test_strided_read();
      test_zero_mask();
      test_write_merge();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got time limit want completion");
      $fatal(1, "watchdog");
   end

endmodule
